radio_slot_sequencer: RTL and testbench

//  Sits between bt_top and BTradio. Owns the shared synthesizer and the tx/rx enables.

---
 rtl/radio_slot_sequencer_if.sv | 24 ++
 rtl/radio_slot_sequencer.sv | 172 +++++++++++++++++
 tb/tb_radio_slot_sequencer.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/radio_slot_sequencer_if.sv
// Link-controller side of the radio slot sequencer:
// burst requests, abort, and status pulses.
interface radio_slot_sequencer_if #(
    parameter int LENW = 12
);
    logic            tx_req_p;
    logic            rx_req_p;
    logic [6:0]      req_fk;
    logic [LENW-1:0] req_len_us;
    logic            abort_p;
    logic            busy;
    logic            done_p;
    logic            drop_p;

    modport master (
        output tx_req_p, rx_req_p, req_fk, req_len_us, abort_p,
        input  busy, done_p, drop_p
    );

    modport slave (
        input  tx_req_p, rx_req_p, req_fk, req_len_us, abort_p,
        output busy, done_p, drop_p
    );
endinterface

// File: rtl/radio_slot_sequencer.sv
// Radio slot sequencer: arbitrates tx/rx bursts, loads the
// synthesizer, waits PLL settle, opens txen/rxen, then guards.
module radio_slot_sequencer #(
    parameter int GUARD_US = 2,
    parameter int LENW     = 12
) (
    input  logic                   clk_6M,
    input  logic                   rstz,
    input  logic                   p_1us,
    input  logic [9:0]             regi_pllsetuptime,
    radio_slot_sequencer_if.slave  lc,
    output logic                   loadfreq_p,
    output logic [6:0]             radio_fk,
    output logic                   txen,
    output logic                   rxen
);
    localparam int CW = (LENW > 10) ? LENW : 10;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_MAX = '1;
    localparam cnt_t GUARD_N = cnt_t'(GUARD_US);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_ACTIVE, S_GUARD
    } state_e;

    state_e          state_q, state_d;
    cnt_t            cnt_q, cnt_d;
    logic [9:0]      set_q, set_d;
    logic            dir_q, dir_d;
    logic [6:0]      fk_q, fk_d;
    logic [LENW-1:0] len_q, len_d;
    logic            pend_v_q, pend_v_d;
    logic            pend_dir_q, pend_dir_d;
    logic [6:0]      pend_fk_q, pend_fk_d;
    logic [LENW-1:0] pend_len_q, pend_len_d;
    logic            done_q, done_d;
    logic            drop_q, drop_d;

    logic is_idle, any_req, counting;
    logic guard_end, seg_end, take_pend, take_req;

    assign is_idle   = (state_q == S_IDLE);
    assign any_req   = lc.tx_req_p | lc.rx_req_p;
    assign counting  = (state_q == S_SETTLE) || (state_q == S_ACTIVE) ||
                       (state_q == S_GUARD);
    assign guard_end = (state_q == S_GUARD) && (cnt_q == GUARD_N);
    assign seg_end   = ((state_q == S_SETTLE) && (cnt_q == cnt_t'(set_q))) ||
                       ((state_q == S_ACTIVE) && (cnt_q == cnt_t'(len_q))) ||
                       guard_end;
    // A pending entry is promoted from IDLE or at the end of the guard.
    assign take_pend = !lc.abort_p && pend_v_q && (is_idle || guard_end);
    assign take_req  = !lc.abort_p && is_idle && !pend_v_q && any_req;

    // State and datapath registers; reset drops the enables at once.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            set_q      <= '0;
            dir_q      <= 1'b0;
            fk_q       <= '0;
            len_q      <= '0;
            pend_v_q   <= 1'b0;
            pend_dir_q <= 1'b0;
            pend_fk_q  <= '0;
            pend_len_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            set_q      <= set_d;
            dir_q      <= dir_d;
            fk_q       <= fk_d;
            len_q      <= len_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            pend_fk_q  <= pend_fk_d;
            pend_len_q <= pend_len_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    // Next-state: abort wins over every phase transition.
    always_comb begin
        state_d = state_q;
        if (lc.abort_p) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (take_pend || take_req) state_d = S_LOAD;
                S_LOAD:   state_d = (regi_pllsetuptime == '0) ? S_ACTIVE : S_SETTLE;
                S_SETTLE: if (seg_end) state_d = S_ACTIVE;
                S_ACTIVE: if (seg_end) state_d = S_GUARD;
                S_GUARD:  if (seg_end) state_d = pend_v_q ? S_LOAD : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath: strobe counter, burst latch, pending slot, pulses.
    always_comb begin
        cnt_d      = cnt_q;
        set_d      = set_q;
        dir_d      = dir_q;
        fk_d       = fk_q;
        len_d      = len_q;
        pend_v_d   = pend_v_q;
        pend_dir_d = pend_dir_q;
        pend_fk_d  = pend_fk_q;
        pend_len_d = pend_len_q;
        done_d     = guard_end && !lc.abort_p;
        drop_d     = 1'b0;

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (p_1us && counting && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        if (state_q == S_LOAD) begin
            set_d = regi_pllsetuptime;
        end

        if (take_pend) begin
            dir_d = pend_dir_q;
            fk_d  = pend_fk_q;
            len_d = pend_len_q;
        end else if (take_req) begin
            dir_d = lc.tx_req_p;
            fk_d  = lc.req_fk;
            len_d = lc.req_len_us;
        end

        if (lc.abort_p) begin
            pend_v_d = 1'b0;
            drop_d   = pend_v_q;
        end else if (take_pend) begin
            pend_v_d = 1'b0;
            drop_d   = any_req;
        end else if (take_req) begin
            if (lc.tx_req_p && lc.rx_req_p) begin
                pend_v_d   = 1'b1;
                pend_dir_d = 1'b0;
                pend_fk_d  = lc.req_fk;
                pend_len_d = lc.req_len_us;
            end
        end else if (any_req && !is_idle) begin
            if (pend_v_q) begin
                drop_d = 1'b1;
            end else begin
                pend_v_d   = 1'b1;
                pend_dir_d = lc.tx_req_p;
                pend_fk_d  = lc.req_fk;
                pend_len_d = lc.req_len_us;
                drop_d     = lc.tx_req_p && lc.rx_req_p;
            end
        end
    end

    // Outputs decoded from the current phase and latched burst.
    always_comb begin
        loadfreq_p = (state_q == S_LOAD);
        txen       = (state_q == S_ACTIVE) && dir_q;
        rxen       = (state_q == S_ACTIVE) && !dir_q;
        radio_fk   = fk_q;
        lc.busy    = !is_idle;
        lc.done_p  = done_q;
        lc.drop_p  = drop_q;
    end
endmodule

// File: tb/tb_radio_slot_sequencer.sv
// Self-checking bench for radio_slot_sequencer: directed table,
// hand sequences and random traffic against a segment-queue model.
module tb_radio_slot_sequencer;
    localparam int LENW     = 12;
    localparam int GUARD_US = 2;
    localparam int K_LOAD   = 0;
    localparam int K_SET    = 1;
    localparam int K_ACT    = 2;
    localparam int K_GRD    = 3;

    logic       clk_6M = 1'b0;
    logic       rstz   = 1'b0;
    logic       p_1us  = 1'b0;
    logic [9:0] regi_pllsetuptime = '0;
    logic       loadfreq_p;
    logic [6:0] radio_fk;
    logic       txen;
    logic       rxen;

    radio_slot_sequencer_if #(.LENW(LENW)) lc();

    radio_slot_sequencer #(.GUARD_US(GUARD_US), .LENW(LENW)) dut (
        .clk_6M            (clk_6M),
        .rstz              (rstz),
        .p_1us             (p_1us),
        .regi_pllsetuptime (regi_pllsetuptime),
        .lc                (lc.slave),
        .loadfreq_p        (loadfreq_p),
        .radio_fk          (radio_fk),
        .txen              (txen),
        .rxen              (rxen)
    );

    always #5 clk_6M = ~clk_6M;

    // p_1us source: 0 = every 6 cycles, 1 = every cycle, 2 = random
    int p_mode = 0;
    initial begin
        int div;
        div = 0;
        forever begin
            @(posedge clk_6M);
            #1;
            case (p_mode)
                0: begin
                    div   = (div == 5) ? 0 : div + 1;
                    p_1us = (div == 0);
                end
                1: p_1us = 1'b1;
                default: p_1us = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // ---------------- reference model ----------------
    // A burst is a queue of segments; each segment lasts until it has
    // seen its required number of microsecond strobes, plus one cycle.
    typedef struct {
        int kind;
        int need;
        int cnt;
    } seg_t;

    typedef struct {
        bit         tx;
        logic [6:0] fk;
        logic [11:0] len;
    } burst_t;

    seg_t   m_segs[$];
    burst_t m_cur;
    burst_t m_pend;
    burst_t m_old;
    bit     m_pend_v;
    bit     m_old_v;
    bit     m_done;
    bit     m_drop;
    bit     m_nd;
    bit     m_nr;
    bit     m_tx;
    bit     m_rx;
    int     m_kind;
    seg_t   m_s;

    function automatic burst_t m_mk(input bit tx);
        burst_t b;
        b.tx  = tx;
        b.fk  = lc.req_fk;
        b.len = lc.req_len_us;
        return b;
    endfunction

    task automatic m_start(input burst_t b);
        m_cur = b;
        m_segs.delete();
        m_segs.push_back('{K_LOAD, 0, 0});
        m_segs.push_back('{K_ACT, int'(b.len), 0});
        m_segs.push_back('{K_GRD, GUARD_US, 0});
    endtask

    always @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            m_segs.delete();
            m_pend_v = 1'b0;
            m_done   = 1'b0;
            m_drop   = 1'b0;
            m_cur    = '{1'b0, 7'd0, 12'd0};
        end else begin
            m_nd = 1'b0;
            m_nr = 1'b0;
            m_tx = lc.tx_req_p;
            m_rx = lc.rx_req_p;
            if (lc.abort_p) begin
                m_nr = m_pend_v;
                m_pend_v = 1'b0;
                m_segs.delete();
            end else if (m_segs.size() == 0) begin
                if (m_pend_v) begin
                    m_start(m_pend);
                    m_pend_v = 1'b0;
                    m_nr = m_tx | m_rx;
                end else if (m_tx) begin
                    m_start(m_mk(1'b1));
                    if (m_rx) begin
                        m_pend   = m_mk(1'b0);
                        m_pend_v = 1'b1;
                    end
                end else if (m_rx) begin
                    m_start(m_mk(1'b0));
                end
            end else begin
                m_old_v = m_pend_v;
                m_old   = m_pend;
                if (m_tx | m_rx) begin
                    if (m_old_v) begin
                        m_nr = 1'b1;
                    end else begin
                        m_pend   = m_mk(m_tx);
                        m_pend_v = 1'b1;
                        m_nr     = m_tx & m_rx;
                    end
                end
                m_s = m_segs[0];
                if (m_s.cnt >= m_s.need) begin
                    m_kind = m_s.kind;
                    void'(m_segs.pop_front());
                    if (m_kind == K_LOAD && regi_pllsetuptime != 0)
                        m_segs.push_front('{K_SET, int'(regi_pllsetuptime), 0});
                    if (m_kind == K_GRD) begin
                        m_nd = 1'b1;
                        if (m_old_v) begin
                            m_start(m_old);
                            m_pend_v = 1'b0;
                        end
                    end
                end else if (p_1us && m_s.kind != K_LOAD) begin
                    m_s.cnt++;
                    m_segs[0] = m_s;
                end
            end
            m_done = m_nd;
            m_drop = m_nr;
        end
    end

    // ---------------- activity monitor ----------------
    int mon_load, mon_tx, mon_rx, mon_done, mon_drop, mon_busy;
    int st_set, st_act, st_grd, ph;
    always @(negedge clk_6M) begin
        if (loadfreq_p) begin
            mon_load++;
            st_set = 0;
            st_act = 0;
            st_grd = 0;
            ph     = 1;
        end else if (txen || rxen) begin
            ph = 2;
            if (p_1us) st_act++;
        end else if (lc.busy) begin
            if (ph == 2) ph = 3;
            if (ph == 1 && p_1us) st_set++;
            if (ph == 3 && p_1us) st_grd++;
        end
        if (txen) mon_tx++;
        if (rxen) mon_rx++;
        if (lc.done_p) mon_done++;
        if (lc.drop_p) mon_drop++;
        if (lc.busy) mon_busy++;
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;
    int s_load, s_tx, s_rx, s_done, s_drop, s_busy;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [12:0] a;
        logic [12:0] e;
        bit eb, el, et, er;
        eb = (m_segs.size() != 0);
        el = eb && (m_segs[0].kind == K_LOAD);
        et = eb && (m_segs[0].kind == K_ACT) && m_cur.tx;
        er = eb && (m_segs[0].kind == K_ACT) && !m_cur.tx;
        a = {loadfreq_p, radio_fk, txen, rxen, lc.busy, lc.done_p, lc.drop_p};
        e = {el, m_cur.fk, et, er, eb, m_done, m_drop};
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL model {load,fk,tx,rx,busy,done,drop}: got %h expected %h (t=%0t)",
                     a, e, $time);
        end
    endtask

    task automatic step();
        @(negedge clk_6M);
        cmp_model();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic req(input bit tx, input bit rx, input int fk, input int len);
        lc.tx_req_p   = tx;
        lc.rx_req_p   = rx;
        lc.req_fk     = 7'(fk);
        lc.req_len_us = 12'(len);
        step();
        lc.tx_req_p = 1'b0;
        lc.rx_req_p = 1'b0;
    endtask

    task automatic snap();
        s_load = mon_load;
        s_tx   = mon_tx;
        s_rx   = mon_rx;
        s_done = mon_done;
        s_drop = mon_drop;
        s_busy = mon_busy;
    endtask

    task automatic wait_idle(input int lim, input string nm);
        for (int i = 0; i < lim && lc.busy; i++) step();
        chk(nm, int'(lc.busy), 0);
        step();
        step();
    endtask

    task automatic wait_en(input bit want_tx, input int lim, input string nm);
        for (int i = 0; i < lim && !(want_tx ? txen : rxen); i++) step();
        chk(nm, int'(want_tx ? txen : rxen), 1);
    endtask

    typedef struct {
        bit tx;
        bit rx;
        int fk;
        int len;
        int setup;
        int e_load;
        int e_tx;
        int e_rx;
        int e_busy;
    } vec_t;

    vec_t vt[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0,  39,    5,    3, 1,    6, 0,   14};
        vt[1] = '{1'b0, 1'b1,  78,    0,    0, 1,    0, 1,    5};
        vt[2] = '{1'b1, 1'b0, 127,   10,    0, 1,   11, 0,   15};
        vt[3] = '{1'b0, 1'b1,   0,    2,    1, 1,    0, 3,    9};
        vt[4] = '{1'b1, 1'b0,   5, 4095, 1023, 1, 4096, 0, 5124};

        lc.tx_req_p   = 1'b0;
        lc.rx_req_p   = 1'b0;
        lc.req_fk     = '0;
        lc.req_len_us = '0;
        lc.abort_p    = 1'b0;

        repeat (3) @(posedge clk_6M);
        #1;
        chk("reset_loadfreq", int'(loadfreq_p), 0);
        chk("reset_radio_fk", int'(radio_fk), 0);
        chk("reset_txen", int'(txen), 0);
        chk("reset_rxen", int'(rxen), 0);
        chk("reset_busy", int'(lc.busy), 0);
        chk("reset_done", int'(lc.done_p), 0);
        chk("reset_drop", int'(lc.drop_p), 0);
        rstz = 1'b1;
        step();

        // table of single bursts, one strobe per cycle
        p_mode = 1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            regi_pllsetuptime = 10'(vt[i].setup);
            snap();
            req(vt[i].tx, vt[i].rx, vt[i].fk, vt[i].len);
            wait_idle(6000, "vec_idle");
            chk("vec_load", mon_load - s_load, vt[i].e_load);
            chk("vec_txen", mon_tx - s_tx, vt[i].e_tx);
            chk("vec_rxen", mon_rx - s_rx, vt[i].e_rx);
            chk("vec_busy", mon_busy - s_busy, vt[i].e_busy);
            chk("vec_done", mon_done - s_done, 1);
            chk("vec_drop", mon_drop - s_drop, 0);
            chk("vec_fk", int'(radio_fk), vt[i].fk);
        end

        // T1: realistic timing, strobe every 6 cycles
        p_mode = 0;
        regi_pllsetuptime = 10'd150;
        repeat (8) step();
        snap();
        req(1'b1, 1'b0, 39, 366);
        chk("t1_loadfreq", int'(loadfreq_p), 1);
        chk("t1_radio_fk", int'(radio_fk), 39);
        step();
        chk("t1_loadfreq_1cyc", int'(loadfreq_p), 0);
        wait_idle(10000, "t1_idle");
        chk("t1_settle_us", st_set, 150);
        chk("t1_active_us", st_act, 366);
        chk("t1_guard_us", st_grd, 2);
        chk("t1_done", mon_done - s_done, 1);
        chk("t1_rxen", mon_rx - s_rx, 0);

        // T2: simultaneous tx and rx requests
        p_mode = 1;
        regi_pllsetuptime = 10'd0;
        step();
        snap();
        req(1'b1, 1'b1, 10, 3);
        wait_idle(200, "t2_idle");
        chk("t2_load", mon_load - s_load, 2);
        chk("t2_txen", mon_tx - s_tx, 4);
        chk("t2_rxen", mon_rx - s_rx, 4);
        chk("t2_done", mon_done - s_done, 2);
        chk("t2_drop", mon_drop - s_drop, 0);

        // T3: three requests while ACTIVE
        snap();
        req(1'b1, 1'b0, 50, 20);
        wait_en(1'b1, 10, "t3_txen");
        req(1'b0, 1'b1, 60, 2);
        req(1'b1, 1'b0, 70, 2);
        req(1'b0, 1'b1, 80, 2);
        wait_idle(300, "t3_idle");
        chk("t3_drop", mon_drop - s_drop, 2);
        chk("t3_load", mon_load - s_load, 2);
        chk("t3_rxen", mon_rx - s_rx, 3);
        chk("t3_fk", int'(radio_fk), 60);
        chk("t3_done", mon_done - s_done, 2);

        // T4: abort during SETTLE with a pending entry
        p_mode = 0;
        regi_pllsetuptime = 10'd100;
        step();
        snap();
        req(1'b1, 1'b0, 30, 10);
        step();
        req(1'b0, 1'b1, 31, 5);
        repeat (5) step();
        lc.abort_p = 1'b1;
        step();
        lc.abort_p = 1'b0;
        chk("t4_busy", int'(lc.busy), 0);
        chk("t4_drop_p", int'(lc.drop_p), 1);
        repeat (30) step();
        chk("t4_txen", mon_tx - s_tx, 0);
        chk("t4_rxen", mon_rx - s_rx, 0);
        chk("t4_done", mon_done - s_done, 0);
        chk("t4_drop", mon_drop - s_drop, 1);

        // T5: no settle, zero length
        regi_pllsetuptime = 10'd0;
        step();
        snap();
        req(1'b1, 1'b0, 3, 0);
        chk("t5_load", int'(loadfreq_p), 1);
        step();
        chk("t5_txen", int'(txen), 1);
        step();
        chk("t5_txen_1cyc", int'(txen), 0);
        wait_idle(100, "t5_idle");
        chk("t5_tx_cycles", mon_tx - s_tx, 1);
        chk("t5_guard_us", st_grd, 2);
        chk("t5_done", mon_done - s_done, 1);

        // T6: reset during ACTIVE
        regi_pllsetuptime = 10'd2;
        step();
        req(1'b1, 1'b0, 9, 50);
        wait_en(1'b1, 100, "t6_txen");
        #2;
        rstz = 1'b0;
        #1;
        chk("t6_txen_async", int'(txen), 0);
        chk("t6_busy_async", int'(lc.busy), 0);
        repeat (3) step();
        rstz = 1'b1;
        snap();
        repeat (20) step();
        chk("t6_busy", int'(lc.busy), 0);
        chk("t6_done", mon_done - s_done, 0);

        // random traffic against the model
        p_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 3)
                regi_pllsetuptime = 10'($urandom_range(0, 5));
            lc.abort_p    = ($urandom_range(0, 59) == 0);
            lc.tx_req_p   = ($urandom_range(0, 14) == 0);
            lc.rx_req_p   = ($urandom_range(0, 14) == 0);
            lc.req_fk     = 7'($urandom_range(0, 127));
            lc.req_len_us = 12'($urandom_range(0, 20));
            step();
        end
        lc.abort_p  = 1'b0;
        lc.tx_req_p = 1'b0;
        lc.rx_req_p = 1'b0;
        wait_idle(2000, "rand_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
